// File: rtl/ccr_pkg.sv
// Shared types and helpers for clock_channel_router.
// Contents:
//   rpt_state_t    - auto-repeat FSM state encoding (IDLE, HOLD, REPEAT)
//   tick_cnt_width - width of the TICK counter shared by the HOLD and REPEAT
//                    phases, never less than 1 bit
package ccr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // The counter only ever holds 0 .. max(hold, repeat)-1.
  function automatic int tick_cnt_width(input int hold_ticks, input int repeat_ticks);
    int span;
    span = (hold_ticks > repeat_ticks) ? hold_ticks : repeat_ticks;
    if (span < 2) begin
      return 1;
    end else begin
      return $clog2(span);
    end
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioning: 2-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk_i   - system clock
//   reset_i - synchronous active-high reset (all flops to 0)
//   btn_i   - asynchronous button level
//   level_o - synchronised button level
//   rise_o  - one-cycle pulse on a synchronised 0->1 transition
module btn_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus a delayed copy of the synchronised level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  // Flops reset to 0, so a button held through reset yields one rise afterwards.
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/clock_channel_router.sv
// Routes the CLEAR / INCREMENT buttons to one of N_CH counter channels
// (channel 0 = clock, others = alarms), with selectable channel source,
// per-press channel latching and hold-to-auto-repeat on INCREMENT.
// Ports:
//   clk_i, reset_i - clock, synchronous active-high reset
//   tick_i         - one-cycle timebase strobe
//   btn_clr_i      - clear button (async level)
//   btn_inc_i      - increment button (async level)
//   btn_sel_i      - select-advance button (used when SEL_MODE=1)
//   s_i            - direct channel select (used when SEL_MODE=0)
//   ch_clr_o       - one-hot one-cycle clear pulse
//   ch_inc_o       - one-hot one-cycle increment pulse
//   active_ch_o    - channel currently targeted
//   repeating_o    - high while the FSM is in REPEAT
module clock_channel_router
  import ccr_pkg::*;
#(
  parameter  int N_CH         = 4,
  parameter  int SEL_MODE     = 0,
  parameter  int HOLD_TICKS   = 500,
  parameter  int REPEAT_TICKS = 100,
  localparam int SEL_W        = $clog2(N_CH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  input  logic             btn_clr_i,
  input  logic             btn_inc_i,
  input  logic             btn_sel_i,
  input  logic [SEL_W-1:0] s_i,
  output logic [N_CH-1:0]  ch_clr_o,
  output logic [N_CH-1:0]  ch_inc_o,
  output logic [SEL_W-1:0] active_ch_o,
  output logic             repeating_o
);

  localparam int               CNT_W       = tick_cnt_width(HOLD_TICKS, REPEAT_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE     = SEL_W'(1);
  localparam logic [SEL_W:0]   N_CH_W      = (SEL_W + 1)'(N_CH);
  localparam logic [N_CH-1:0]  CH0_HOT     = {{(N_CH-1){1'b0}}, 1'b1};

  logic inc_level_s, inc_rise_s;
  logic clr_level_s, clr_rise_s;
  logic sel_level_s, sel_rise_s;
  logic unused_levels_s;

  rpt_state_t       state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [SEL_W-1:0] sel_lat_q, sel_lat_d;
  logic [N_CH-1:0]  ch_clr_q, ch_clr_d;
  logic [N_CH-1:0]  ch_inc_q, ch_inc_d;
  logic             inc_fire_s, clr_fire_s;
  logic [SEL_W-1:0] inc_ch_s, clr_ch_s;

  btn_sync_edge u_sync_inc (.clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_inc_i),
                            .level_o(inc_level_s), .rise_o(inc_rise_s));
  btn_sync_edge u_sync_clr (.clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_clr_i),
                            .level_o(clr_level_s), .rise_o(clr_rise_s));
  btn_sync_edge u_sync_sel (.clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_sel_i),
                            .level_o(sel_level_s), .rise_o(sel_rise_s));

  // Only the edges of CLR and SEL matter; their levels are deliberately dropped.
  assign unused_levels_s = clr_level_s ^ sel_level_s;

  // Channel pointer: frozen while a press is in progress, so pending S
  // changes land on the first IDLE cycle and SEL edges are discarded.
  always_comb begin
    active_d = active_q;
    if (state_q != IDLE) begin
      active_d = active_q;
    end else if (SEL_MODE == 0) begin
      if ({1'b0, s_i} < N_CH_W) begin
        active_d = s_i;
      end else begin
        active_d = active_q;
      end
    end else begin
      if (!sel_rise_s) begin
        active_d = active_q;
      end else if (active_q == LAST_CH) begin
        active_d = {SEL_W{1'b0}};
      end else begin
        active_d = active_q + SEL_ONE;
      end
    end
  end

  // Auto-repeat FSM, per-press channel latching and clear arbitration.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    sel_lat_d  = sel_lat_q;
    inc_fire_s = 1'b0;
    inc_ch_s   = sel_lat_q;
    clr_fire_s = 1'b0;
    clr_ch_s   = sel_lat_q;
    case (state_q)
      IDLE: begin
        if (inc_rise_s) begin
          inc_fire_s = 1'b1;
          inc_ch_s   = active_q;
          sel_lat_d  = active_q;
          tick_cnt_d = CNT_ZERO;
          state_d    = HOLD;
        end else begin
          state_d    = IDLE;
        end
      end
      HOLD: begin
        // Release is checked first so a coincident TICK yields no pulse.
        if (!inc_level_s) begin
          state_d    = IDLE;
          tick_cnt_d = CNT_ZERO;
        end else if (!tick_i) begin
          state_d    = HOLD;
        end else if (tick_cnt_q == HOLD_LAST) begin
          inc_fire_s = 1'b1;
          tick_cnt_d = CNT_ZERO;
          state_d    = REPEAT;
        end else begin
          tick_cnt_d = tick_cnt_q + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!inc_level_s) begin
          state_d    = IDLE;
          tick_cnt_d = CNT_ZERO;
        end else if (!tick_i) begin
          state_d    = REPEAT;
        end else if (tick_cnt_q == REPEAT_LAST) begin
          inc_fire_s = 1'b1;
          tick_cnt_d = CNT_ZERO;
        end else begin
          tick_cnt_d = tick_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = IDLE;
        tick_cnt_d = CNT_ZERO;
      end
    endcase
    // Clear pre-empts whatever the FSM decided this cycle; the repeat only
    // restarts on a fresh INC press.
    if (clr_rise_s) begin
      clr_fire_s = 1'b1;
      clr_ch_s   = (state_q == IDLE) ? active_q : sel_lat_q;
      inc_fire_s = 1'b0;
      state_d    = IDLE;
      tick_cnt_d = CNT_ZERO;
    end else begin
      clr_fire_s = 1'b0;
    end
  end

  assign ch_clr_d = clr_fire_s ? (CH0_HOT << clr_ch_s) : {N_CH{1'b0}};
  assign ch_inc_d = inc_fire_s ? (CH0_HOT << inc_ch_s) : {N_CH{1'b0}};

  // State and output pulse registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tick_cnt_q <= CNT_ZERO;
      active_q   <= {SEL_W{1'b0}};
      sel_lat_q  <= {SEL_W{1'b0}};
      ch_clr_q   <= {N_CH{1'b0}};
      ch_inc_q   <= {N_CH{1'b0}};
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      active_q   <= active_d;
      sel_lat_q  <= sel_lat_d;
      ch_clr_q   <= ch_clr_d;
      ch_inc_q   <= ch_inc_d;
    end
  end

  assign ch_clr_o    = ch_clr_q;
  assign ch_inc_o    = ch_inc_q;
  assign active_ch_o = active_q;
  assign repeating_o = (state_q == REPEAT);

endmodule

// File: tb/tb_clock_channel_router.sv
// Self-checking bench for clock_channel_router.
//   dut_a: N_CH=4, bus select, HOLD_TICKS=3, REPEAT_TICKS=2 (main checks)
//   dut_b: N_CH=5, button select (pointer wrap, S ignored)
//   dut_c: N_CH=5, bus select (out-of-range S held)
// Pulses from dut_a are checked against a queue of expected
// {edge, clr, inc} entries pushed when the stimulus is driven.
module tb_clock_channel_router;

  logic clk;
  logic rst;
  logic lo = 1'b0;
  int   edge_n = 0;

  logic       tick_a, btn_clr_a, btn_inc_a;
  logic [1:0] s_a;
  logic [3:0] ch_clr_a, ch_inc_a;
  logic [1:0] act_a;
  logic       rep_a;

  logic       btn_sel_b;
  logic [2:0] s_b;
  logic [4:0] ch_clr_b, ch_inc_b;
  logic [2:0] act_b;
  logic       rep_b;

  logic [2:0] s_c;
  logic [4:0] ch_clr_c, ch_inc_c;
  logic [2:0] act_c;
  logic       rep_c;

  clock_channel_router #(.N_CH(4), .SEL_MODE(0), .HOLD_TICKS(3), .REPEAT_TICKS(2)) dut_a (
    .clk_i(clk), .reset_i(rst), .tick_i(tick_a), .btn_clr_i(btn_clr_a),
    .btn_inc_i(btn_inc_a), .btn_sel_i(lo), .s_i(s_a), .ch_clr_o(ch_clr_a),
    .ch_inc_o(ch_inc_a), .active_ch_o(act_a), .repeating_o(rep_a));

  clock_channel_router #(.N_CH(5), .SEL_MODE(1), .HOLD_TICKS(3), .REPEAT_TICKS(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .tick_i(lo), .btn_clr_i(lo),
    .btn_inc_i(lo), .btn_sel_i(btn_sel_b), .s_i(s_b), .ch_clr_o(ch_clr_b),
    .ch_inc_o(ch_inc_b), .active_ch_o(act_b), .repeating_o(rep_b));

  clock_channel_router #(.N_CH(5), .SEL_MODE(0), .HOLD_TICKS(3), .REPEAT_TICKS(2)) dut_c (
    .clk_i(clk), .reset_i(rst), .tick_i(lo), .btn_clr_i(lo),
    .btn_inc_i(lo), .btn_sel_i(lo), .s_i(s_c), .ch_clr_o(ch_clr_c),
    .ch_inc_o(ch_inc_c), .active_ch_o(act_c), .repeating_o(rep_c));

  typedef struct {
    int         at_edge;
    logic [3:0] clr;
    logic [3:0] inc;
  } exp_t;

  typedef struct {
    bit         op;   // 0 = INC press, 1 = CLR press
    logic [1:0] s;
    logic [1:0] act;
    logic [3:0] clr;
    logic [3:0] inc;
  } vec_t;

  typedef struct {
    logic [2:0] s;
    logic [2:0] act;
  } sel_vec_t;

  exp_t sb_q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp_v, edge_n);
    end
  endtask

  task automatic push(input int at_edge, input logic [3:0] clr, input logic [3:0] inc);
    exp_t e;
    e.at_edge = at_edge;
    e.clr     = clr;
    e.inc     = inc;
    sb_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor for dut_a pulses, sampled on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].at_edge < edge_n) begin
      n_cmp++;
      n_err++;
      $display("FAIL missed_pulse: expected clr=%b inc=%b at edge %0d, did not arrive",
               sb_q[0].clr, sb_q[0].inc, sb_q[0].at_edge);
      void'(sb_q.pop_front());
    end
    if ((ch_clr_a | ch_inc_a) != 4'b0000) begin
      chk("onehot", $countones(ch_clr_a | ch_inc_a), 1);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: clr=%b inc=%b at edge %0d, expected none",
                 ch_clr_a, ch_inc_a, edge_n);
      end else begin
        e_mon = sb_q.pop_front();
        chk("pulse_edge", edge_n, e_mon.at_edge);
        chk("pulse_clr", ch_clr_a, e_mon.clr);
        chk("pulse_inc", ch_inc_a, e_mon.inc);
      end
    end
    if ((ch_clr_b | ch_inc_b | ch_clr_c | ch_inc_c) != 5'b00000) begin
      chk("bc_quiet", {ch_clr_b, ch_inc_b, ch_clr_c, ch_inc_c}, 0);
    end
  end

  vec_t     tbl[6];
  sel_vec_t tbl_c[7];
  int       sel_exp[6];
  int       p_edge, t3, rel_e, ticks_seen, ce, exp_rep, exp_act;

  initial begin
    tbl[0] = '{1'b0, 2'd2, 2'd2, 4'b0000, 4'b0100};
    tbl[1] = '{1'b0, 2'd0, 2'd0, 4'b0000, 4'b0001};
    tbl[2] = '{1'b1, 2'd3, 2'd3, 4'b1000, 4'b0000};
    tbl[3] = '{1'b0, 2'd3, 2'd3, 4'b0000, 4'b1000};
    tbl[4] = '{1'b1, 2'd1, 2'd1, 4'b0010, 4'b0000};
    tbl[5] = '{1'b0, 2'd1, 2'd1, 4'b0000, 4'b0010};
    tbl_c[0] = '{3'd3, 3'd3};
    tbl_c[1] = '{3'd7, 3'd3};
    tbl_c[2] = '{3'd4, 3'd4};
    tbl_c[3] = '{3'd5, 3'd4};
    tbl_c[4] = '{3'd0, 3'd0};
    tbl_c[5] = '{3'd6, 3'd0};
    tbl_c[6] = '{3'd2, 3'd2};
    sel_exp = '{1, 2, 3, 4, 0, 1};

    rst = 1'b1;
    tick_a = 1'b0; btn_clr_a = 1'b0; btn_inc_a = 1'b0; s_a = 2'd0;
    btn_sel_b = 1'b0; s_b = 3'd7; s_c = 3'd0;

    // Reset state.
    wait_n(3);
    chk("rst_clr_a", ch_clr_a, 0);
    chk("rst_inc_a", ch_inc_a, 0);
    chk("rst_act_a", act_a, 0);
    chk("rst_rep_a", rep_a, 0);
    chk("rst_act_b", act_b, 0);
    chk("rst_act_c", act_c, 0);
    rst = 1'b0;
    wait_n(2);

    // Bus select with out-of-range values held (N_CH=5).
    for (int i = 0; i < 7; i++) begin
      s_c = tbl_c[i].s;
      wait_n(1);
      chk("sel_bus_c", act_c, tbl_c[i].act);
    end

    // Button select pointer with wrap; S=7 ignored.
    for (int i = 0; i < 6; i++) begin
      btn_sel_b = 1'b1;
      wait_n(3);
      btn_sel_b = 1'b0;
      wait_n(3);
      chk("sel_btn_b", act_b, sel_exp[i]);
    end

    // Table: single presses routed to the selected channel.
    for (int i = 0; i < 6; i++) begin
      s_a = tbl[i].s;
      wait_n(1);
      chk("tbl_act", act_a, tbl[i].act);
      if (tbl[i].op) btn_clr_a = 1'b1;
      else btn_inc_a = 1'b1;
      push(edge_n + 3, tbl[i].clr, tbl[i].inc);
      wait_n(5);
      chk("tbl_rep", rep_a, 0);
      btn_clr_a = 1'b0;
      btn_inc_a = 1'b0;
      wait_n(6);
    end

    // Hold-to-repeat on ch1 for 40 ticks, S moved to 3 mid-repeat.
    s_a = 2'd1;
    wait_n(2);
    btn_inc_a = 1'b1;
    p_edge = edge_n + 3;
    push(p_edge, 4'b0000, 4'b0010);
    ticks_seen = 0; t3 = 0; rel_e = 0;
    for (int c = 0; c < 200; c++) begin
      exp_rep = (t3 != 0 && edge_n >= t3 && (rel_e == 0 || edge_n < rel_e + 3)) ? 1 : 0;
      exp_act = (rel_e != 0 && edge_n >= rel_e + 4) ? 3 : 1;
      chk("rpt_rep", rep_a, exp_rep);
      chk("rpt_act", act_a, exp_act);
      if (c == 40) s_a = 2'd3;
      if (ticks_seen >= 40 && rel_e == 0) begin
        btn_inc_a = 1'b0;
        rel_e = edge_n;
      end
      tick_a = (c > 0 && (c % 4) == 0);
      if (tick_a && (edge_n + 1) > p_edge && (rel_e == 0 || (edge_n + 1) <= rel_e + 2)) begin
        ticks_seen++;
        if (ticks_seen == 3) begin
          t3 = edge_n + 1;
          push(edge_n + 1, 4'b0000, 4'b0010);
        end else if (ticks_seen > 3 && ((ticks_seen - 3) % 2) == 0) begin
          push(edge_n + 1, 4'b0000, 4'b0010);
        end
      end
      wait_n(1);
    end
    tick_a = 1'b0;
    wait_n(4);

    // Clear during REPEAT on ch0, coinciding with a tick that would fire.
    s_a = 2'd0;
    wait_n(2);
    btn_inc_a = 1'b1;
    push(edge_n + 3, 4'b0000, 4'b0001);
    wait_n(5);
    for (int i = 0; i < 3; i++) begin
      tick_a = 1'b1;
      if (i == 2) push(edge_n + 1, 4'b0000, 4'b0001);
      wait_n(1);
      tick_a = 1'b0;
      wait_n(1);
    end
    chk("clr_pre_rep", rep_a, 1);
    tick_a = 1'b1;
    wait_n(1);
    tick_a = 1'b0;
    s_a = 2'd2;
    btn_clr_a = 1'b1;
    ce = edge_n;
    wait_n(2);
    tick_a = 1'b1;
    push(ce + 3, 4'b0001, 4'b0000);
    wait_n(1);
    tick_a = 1'b0;
    chk("clr_rep", rep_a, 0);
    chk("clr_act_hold", act_a, 0);
    wait_n(1);
    chk("clr_act_idle", act_a, 2);
    for (int i = 0; i < 6; i++) begin
      tick_a = 1'b1;
      wait_n(1);
      tick_a = 1'b0;
      wait_n(1);
    end
    btn_inc_a = 1'b0;
    btn_clr_a = 1'b0;
    wait_n(6);

    // Reset mid-HOLD with INC held and a would-be repeat tick on the reset edge.
    btn_inc_a = 1'b1;
    push(edge_n + 3, 4'b0000, 4'b0100);
    wait_n(5);
    for (int i = 0; i < 2; i++) begin
      tick_a = 1'b1;
      wait_n(1);
      tick_a = 1'b0;
      wait_n(1);
    end
    rst = 1'b1;
    tick_a = 1'b1;
    wait_n(1);
    tick_a = 1'b0;
    chk("rstmid_clr", ch_clr_a, 0);
    chk("rstmid_inc", ch_inc_a, 0);
    chk("rstmid_act", act_a, 0);
    chk("rstmid_rep", rep_a, 0);
    wait_n(1);
    rst = 1'b0;
    push(edge_n + 3, 4'b0000, 4'b0100);
    wait_n(1);
    chk("rstmid_act_s", act_a, 2);
    wait_n(8);
    btn_inc_a = 1'b0;
    wait_n(6);

    while (sb_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL missed_pulse: expected clr=%b inc=%b at edge %0d, did not arrive",
               sb_q[0].clr, sb_q[0].inc, sb_q[0].at_edge);
      void'(sb_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_channel_router.md
# clock_channel_router

Parametrised successor to the fixed 4-way clock/alarm control demux. It routes the user CLEAR and INCREMENT buttons to one of N_CH counter channels (channel 0 = clock, 1..N_CH-1 = alarms). Added behaviour over the fixed demux:
- button synchronisation and edge detection;
- a selectable select mode (direct bus or cycling button);
- per-press selection latching;
- hold-to-auto-repeat on INCREMENT.

It sits between the board button inputs and the per-channel BCD counters, which consume one-cycle clear/increment pulses.

## Interface
- N_CH, 4: number of channels, 2..16. SEL_W = $clog2(N_CH) is derived, not overridable.
- SEL_MODE, 0: 0 = channel taken from the S bus; 1 = BTN_SEL press advances an internal pointer.
- HOLD_TICKS, 500: TICK strobes INCREMENT must be held before auto-repeat starts. Must be ≥1.
- REPEAT_TICKS, 100: TICK strobes between auto-repeat pulses. Must be ≥1.

Ports:
- CLK  in  1  system clock. One clock domain; all logic on posedge CLK.
- RESET  in  1  synchronous, active-high block reset.
- TICK  in  1  one-cycle timebase strobe (e.g. 1 kHz), synchronous to CLK.
- BTN_CLR  in  1  user clear button, asynchronous level.
- BTN_INC  in  1  user increment button, asynchronous level.
- BTN_SEL  in  1  select-advance button, asynchronous level. Ignored when SEL_MODE=0.
- S  in  SEL_W  direct channel select. Ignored when SEL_MODE=1.
- CH_CLR  out  N_CH  one-hot, one-cycle clear pulse to the selected channel.
- CH_INC  out  N_CH  one-hot, one-cycle increment pulse to the selected channel.
- ACTIVE_CH  out  SEL_W  channel currently targeted.
- REPEATING  out  1  high while the auto-repeat FSM is in REPEAT.

## Operation
**Input conditioning**
- Each BTN_* passes through a 2-flop synchroniser, then a rising-edge detector.
- Sync flops reset to 0. A button held through RESET therefore registers one press after RESET deasserts.

**Channel selection**
- SEL_MODE=0:
  - ACTIVE_CH follows S, registered.
  - S ≥ N_CH is ignored; the previous value is held.
- SEL_MODE=1:
  - A BTN_SEL edge increments the pointer, wrapping from N_CH-1 to 0.

**Selection latching**
- On an INCREMENT press edge, the target channel is latched into sel_lat. All pulses of that press (first pulse and repeats) go to sel_lat.
- While the FSM is not IDLE:
  - S changes are not applied to ACTIVE_CH.
  - BTN_SEL edges are discarded.
- Pending S changes are applied on the first cycle back in IDLE.

**Auto-repeat FSM** (states IDLE, HOLD, REPEAT)
- IDLE:
  - INC edge → pulse CH_INC[ACTIVE_CH], latch sel_lat, clear tick_cnt, go to HOLD.
- HOLD:
  - synced INC low → IDLE, no pulse.
  - On TICK, tick_cnt increments.
  - When TICK arrives with tick_cnt == HOLD_TICKS-1 → pulse, clear tick_cnt, go to REPEAT.
- REPEAT:
  - synced INC low → IDLE.
  - When TICK arrives with tick_cnt == REPEAT_TICKS-1 → pulse, clear tick_cnt.
- tick_cnt width is $clog2(max(HOLD_TICKS, REPEAT_TICKS)). No overflow is possible.

**Clear**
- A CLR edge pulses CH_CLR[ACTIVE_CH] when the FSM is IDLE, otherwise CH_CLR[sel_lat].
- Clear has priority. In that same cycle:
  - any CH_INC pulse is suppressed;
  - the FSM is forced to IDLE.
- Repeat resumes only on a new INC press.

**Output invariants**
- At most one bit of CH_CLR | CH_INC is high in any cycle.

## Timing
- Reset values:
  - CH_CLR = 0, CH_INC = 0, ACTIVE_CH = 0, REPEATING = 0;
  - FSM = IDLE, tick_cnt = 0, pointer = 0, all sync/edge flops = 0.
- Press latency: BTN first sampled high at edge k → output pulse high in the cycle after edge k+2. That is 3 edges.
- Release latency: identical, 3 edges. Up to 2 extra repeat pulses may still emit during this window.
- TICK-driven pulses are registered: TICK at edge t → pulse in the cycle after edge t.
- S → ACTIVE_CH: 1 cycle when the FSM is IDLE.
- RESET mid-HOLD or mid-REPEAT: outputs return to 0 on the next edge. No residual pulse.
- TICK coinciding with release: release wins, no pulse.
- TICK coinciding with a CLR edge: clear wins.

## Structure
- Package `ccr_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t`;
  - a localparam function computing the tick_cnt width.
- Sub-module `btn_sync_edge`:
  - 2-flop synchroniser plus edge register;
  - outputs `level` and `rise`;
  - instantiated 3×.
- Top level holds the select logic, the FSM and the output decode. Target 150–250 lines.

## Test plan
- N_CH=4, SEL_MODE=0, S=2, BTN_INC pulse of 5 cycles → CH_INC = 4'b0100 for exactly one cycle, 3 edges after press. REPEATING stays 0.
- HOLD_TICKS=3, REPEAT_TICKS=2, TICK every 4 cycles, INC held for 40 ticks → first pulse, then a pulse on tick 3, then one every 2 ticks. REPEATING goes high at tick 3. No pulse after release.
- During REPEAT on ch1, S changes to 3 → all pulses stay on bit 1. ACTIVE_CH = 3 one cycle after the FSM returns to IDLE.
- SEL_MODE=1, N_CH=5, 6 BTN_SEL presses → ACTIVE_CH sequence 1, 2, 3, 4, 0, 1. S=7 is ignored.
- CLR edge during REPEAT on ch0 → CH_CLR = 1 for one cycle, no CH_INC that cycle, FSM = IDLE, REPEATING = 0.
- RESET asserted mid-HOLD with BTN_INC held → all outputs 0. A single new press is seen 3 edges after RESET deasserts.
